// File: rtl/mc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_pkg : shared encodings for the multi-cycle MIPS control unit    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mc_pkg;

    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_IF      = 4'd1,
        S_IW      = 4'd2,
        S_ID      = 4'd3,
        S_EX_R    = 4'd4,
        S_RWB     = 4'd5,
        S_EX_I    = 4'd6,
        S_IWB     = 4'd7,
        S_MADDR   = 4'd8,
        S_LD_REQ  = 4'd9,
        S_LD_WAIT = 4'd10,
        S_LWB     = 4'd11,
        S_ST_REQ  = 4'd12,
        S_BR      = 4'd13,
        S_JMP     = 4'd14
    } state_t;

    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADDU = 6'b100001;
    localparam logic [5:0] c_FN_SUBU = 6'b100011;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;

    localparam logic [1:0] c_SRCB_RT      = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
    localparam logic [1:0] c_SRCB_IMM     = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_alu_dec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_alu_dec : R-type funct to ALU control code, with supported flag |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic       o_supported
);

    always_comb begin
        o_alu_op    = c_ALU_AND;
        o_supported = 1'b1;
        case (i_funct)
            c_FN_ADDU: o_alu_op = c_ALU_ADD;
            c_FN_SUBU: o_alu_op = c_ALU_SUB;
            c_FN_AND:  o_alu_op = c_ALU_AND;
            c_FN_OR:   o_alu_op = c_ALU_OR;
            c_FN_SLT:  o_alu_op = c_ALU_SLT;
            default:   o_supported = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_ctrl : multi-cycle MIPS control FSM with memory handshake       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       Mem_Req_Ready,
    input  logic       Read_data_Valid,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic [2:0] ALUop,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       Inst_Retired
);

    state_t     r_state;
    logic [2:0] w_fn_alu_op;
    logic       w_fn_ok;

    mc_alu_dec u_alu_dec (
        .i_funct     (funct),
        .o_alu_op    (w_fn_alu_op),
        .o_supported (w_fn_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            case (r_state)
                S_INIT:    r_state <= S_IF;
                S_IF:      if (Mem_Req_Ready) r_state <= S_IW;
                S_IW:      if (Read_data_Valid) r_state <= S_ID;
                S_ID: begin
                    case (opcode)
                        c_OP_RTYPE:       r_state <= S_EX_R;
                        c_OP_ADDIU:       r_state <= S_EX_I;
                        c_OP_LW, c_OP_SW: r_state <= S_MADDR;
                        c_OP_BEQ, c_OP_BNE: r_state <= S_BR;
                        c_OP_J:           r_state <= S_JMP;
                        default:          r_state <= S_IF;
                    endcase
                end
                S_EX_R:    r_state <= w_fn_ok ? S_RWB : S_IF;
                S_EX_I:    r_state <= S_IWB;
                S_MADDR:   r_state <= (opcode == c_OP_LW) ? S_LD_REQ : S_ST_REQ;
                S_LD_REQ:  if (Mem_Req_Ready) r_state <= S_LD_WAIT;
                S_LD_WAIT: if (Read_data_Valid) r_state <= S_LWB;
                S_ST_REQ:  if (Mem_Req_Ready) r_state <= S_IF;
                S_RWB, S_IWB, S_LWB, S_BR, S_JMP: r_state <= S_IF;
                default:   r_state <= S_INIT;
            endcase
        end
    end

    // Outputs are a pure decode of state plus live inputs, so async reset zeroes them at once.
    always_comb begin
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCSource     = c_PCSRC_ALU;
        ALUop        = c_ALU_AND;
        ALUSrcA      = 1'b0;
        ALUSrcB      = c_SRCB_RT;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        Inst_Retired = 1'b0;
        case (r_state)
            S_IF: MemRead = 1'b1;
            S_IW: begin
                ALUSrcB  = c_SRCB_FOUR;
                ALUop    = c_ALU_ADD;
                PCSource = c_PCSRC_ALU;
                IRWrite  = Read_data_Valid;
                PCWrite  = Read_data_Valid;
            end
            S_ID: begin
                ALUSrcB = c_SRCB_IMM_SH2;
                ALUop   = c_ALU_ADD;
            end
            S_EX_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_SRCB_RT;
                ALUop   = w_fn_alu_op;
            end
            S_EX_I, S_MADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_SRCB_IMM;
                ALUop   = c_ALU_ADD;
            end
            S_RWB: begin
                RegWrite     = 1'b1;
                RegDst       = 1'b1;
                Inst_Retired = 1'b1;
            end
            S_IWB: begin
                RegWrite     = 1'b1;
                Inst_Retired = 1'b1;
            end
            S_LD_REQ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_LWB: begin
                RegWrite     = 1'b1;
                MemtoReg     = 1'b1;
                Inst_Retired = 1'b1;
            end
            S_ST_REQ: begin
                MemWrite     = 1'b1;
                IorD         = 1'b1;
                Inst_Retired = Mem_Req_Ready;
            end
            S_BR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = c_SRCB_RT;
                ALUop        = c_ALU_SUB;
                PCSource     = c_PCSRC_ALUOUT;
                PCWrite      = Zero ^ (opcode == c_OP_BNE);
                Inst_Retired = 1'b1;
            end
            S_JMP: begin
                PCSource     = c_PCSRC_JUMP;
                PCWrite      = 1'b1;
                Inst_Retired = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
